// File: rtl/spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// spi_ram_arbiter
//
// Shares one single-port RAM between an SPI command stream and a local
// requester. SPI commands are two-bit opcodes plus a WIDTH-bit payload:
//   00 load write address   01 write payload at write address
//   10 load read address    11 read at read address (data returned on tx_*)
// Opcodes 01/11 occupy a one-deep pending slot; a further 01/11 while the
// slot is full is dropped and sets the sticky a_ovf flag.
//
// A three-state FSM (IDLE -> ACCESS -> WAIT) serves one access at a time:
// grant in IDLE at cycle N, ram_en at N+1, read data captured in WAIT,
// completion strobe at N+3. Ties go round-robin (SPI wins the first one).
//
// Configuration macro:
//   SPI_ARB_FIXED_PRIO_EN  defined: SPI always wins a tie, no last-grant flop.
//                          undefined (default): round-robin tie-break.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_data/rx_valid    SPI command word and its one-cycle strobe
//   tx_data/tx_valid    SPI read-return data and its one-cycle strobe
//   b_req/b_we/b_addr/b_wdata  local level request, held until b_ack
//   b_ack/b_rdata       local completion strobe and read data
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  single-port RAM interface
//   a_ovf               sticky: an SPI RAM command was dropped
//   busy                FSM is in ACCESS or WAIT
// -----------------------------------------------------------------------------
module spi_ram_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH+1:0] rx_data,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_ack,
  output logic [WIDTH-1:0] b_rdata,
  output logic             ram_en,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic             a_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0] OP_SET_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_SET_RADDR = 2'b10;

  state_t           r_state;
  logic [WIDTH-1:0] r_wr_addr;
  logic [WIDTH-1:0] r_rd_addr;

  // One-deep SPI pending slot; the address is frozen when the command
  // arrives so later address loads cannot retarget it.
  logic             r_spi_pend;
  logic             r_spi_we;
  logic [WIDTH-1:0] r_spi_addr;
  logic [WIDTH-1:0] r_spi_wdata;

  // Command latched at grant, needed again in WAIT after ram_we drops.
  logic             r_cmd_spi;
  logic             r_cmd_we;

`ifndef SPI_ARB_FIXED_PRIO_EN
  logic             r_last_local;   // 1: local requester was granted last
`endif

  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_payload;
  logic             w_spi_cmd;
  logic             w_loc_pend;
  logic             w_any_pend;
  logic             w_grant_spi;

  assign w_op      = rx_data[WIDTH+1:WIDTH];
  assign w_payload = rx_data[WIDTH-1:0];
  // Opcodes 01 and 11 are the RAM-accessing ones (bit 0 set).
  assign w_spi_cmd = rx_valid & w_op[0];
  // The requester still holds b_req in its ack cycle; that level is stale.
  assign w_loc_pend = b_req & ~b_ack;
  assign w_any_pend = r_spi_pend | w_loc_pend;

`ifdef SPI_ARB_FIXED_PRIO_EN
  assign w_grant_spi = r_spi_pend;
`else
  assign w_grant_spi = r_spi_pend & (~w_loc_pend | r_last_local);
`endif

  assign busy = (r_state != ST_IDLE);

  // NOTE: every register below uses non-blocking assignment so all of them
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_spi_pend   <= 1'b0;
      r_spi_we     <= 1'b0;
      r_spi_addr   <= '0;
      r_spi_wdata  <= '0;
      r_cmd_spi    <= 1'b0;
      r_cmd_we     <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      r_last_local <= 1'b1;
`endif
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      b_ack        <= 1'b0;
      b_rdata      <= '0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      a_ovf        <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      b_ack    <= 1'b0;

      // SPI command decode runs every cycle, independent of the FSM, so a
      // strobe during an access only touches the address/pending registers.
      if (rx_valid) begin
        case (w_op)
          OP_SET_WADDR: r_wr_addr <= w_payload;
          OP_SET_RADDR: r_rd_addr <= w_payload;
          default:      ;
        endcase
      end
      if (w_spi_cmd) begin
        if (r_spi_pend) begin
          a_ovf <= 1'b1;
        end else begin
          r_spi_pend  <= 1'b1;
          r_spi_we    <= (w_op == OP_WRITE);
          r_spi_addr  <= (w_op == OP_WRITE) ? r_wr_addr : r_rd_addr;
          r_spi_wdata <= w_payload;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_any_pend) begin
            r_state   <= ST_ACCESS;
            ram_en    <= 1'b1;
            r_cmd_spi <= w_grant_spi;
`ifndef SPI_ARB_FIXED_PRIO_EN
            r_last_local <= ~w_grant_spi;
`endif
            if (w_grant_spi) begin
              // Grant needs r_spi_pend=1 and acceptance needs it at 0, so
              // this clear never collides with a new command being taken.
              r_spi_pend <= 1'b0;
              r_cmd_we   <= r_spi_we;
              ram_we     <= r_spi_we;
              ram_addr   <= r_spi_addr;
              ram_wdata  <= r_spi_wdata;
            end else begin
              r_cmd_we   <= b_we;
              ram_we     <= b_we;
              ram_addr   <= b_addr;
              ram_wdata  <= b_wdata;
            end
          end
        end

        ST_ACCESS: begin
          ram_en  <= 1'b0;
          ram_we  <= 1'b0;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          r_state <= ST_IDLE;
          if (r_cmd_spi) begin
            // SPI writes complete silently.
            if (!r_cmd_we) begin
              tx_data  <= ram_rdata;
              tx_valid <= 1'b1;
            end
          end else begin
            b_ack <= 1'b1;
            if (!r_cmd_we) begin
              b_rdata <= ram_rdata;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_arbiter
//
// The bench provides the RAM, drives SPI commands and a local requester, and
// keeps a timeline model: each grant decided in cycle N books ram_en for
// N+1 and a strobe for N+3 in per-cycle expectation arrays. A negedge
// process compares every DUT output with those arrays each cycle. Directed
// sequences with literal expectations come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_spi_ram_arbiter;

  localparam int W    = 8;
  localparam int NCYC = 2048;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W+1:0] rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         b_req = 1'b0;
  logic         b_we = 1'b0;
  logic [W-1:0] b_addr = '0;
  logic [W-1:0] b_wdata = '0;
  logic         b_ack;
  logic [W-1:0] b_rdata;
  logic         ram_en;
  logic         ram_we;
  logic [W-1:0] ram_addr;
  logic [W-1:0] ram_wdata;
  logic [W-1:0] ram_rdata = '0;
  logic         a_ovf;
  logic         busy;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .a_ovf     (a_ovf),
    .busy      (busy)
  );

  // ---------------------------------------------------------------- RAM
  logic [W-1:0] ram_mem [256];
  int           wr40_cnt = 0;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_wdata;
        if (ram_addr == 8'h40) wr40_cnt <= wr40_cnt + 1;
      end else begin
        ram_rdata <= ram_mem[ram_addr];
      end
    end
  end

  // ---------------------------------------------------------------- checking
  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  // ---------------------------------------------------------------- model
  bit           e_en   [NCYC];
  bit           e_we   [NCYC];
  bit           e_txv  [NCYC];
  bit           e_back [NCYC];
  bit           e_busy [NCYC];
  logic [W-1:0] e_addr [NCYC];
  logic [W-1:0] e_wd   [NCYC];
  logic [W-1:0] e_rd   [NCYC];
  logic [W-1:0] mmem   [256];

  logic [W-1:0] m_wr = '0, m_rd = '0, m_tx_data = '0, m_b_rdata = '0;
  logic [W-1:0] m_paddr = '0, m_pdata = '0;
  bit           m_pend = 0, m_pwe = 0, m_ovf = 0, m_last_local = 1;
  int           m_free = 0;

  always @(posedge clk) begin : model
    logic       loc, pend0, spi_win;
    logic [1:0] op;
    logic [W-1:0] pl;
    if (rst) begin
      m_wr = '0; m_rd = '0; m_tx_data = '0; m_b_rdata = '0;
      m_pend = 0; m_ovf = 0; m_last_local = 1; m_free = 0;
      for (int i = 0; i < NCYC; i++) begin
        e_en[i] = 0; e_we[i] = 0; e_txv[i] = 0; e_back[i] = 0; e_busy[i] = 0;
      end
    end else begin
      // RAM effect of the access whose enable is in this cycle
      if (e_en[cyc]) begin
        if (e_we[cyc]) mmem[e_addr[cyc]] = e_wd[cyc];
        else           e_rd[cyc+2] = mmem[e_addr[cyc]];
      end
      loc   = b_req && !e_back[cyc];
      pend0 = m_pend;
      if (cyc >= m_free && (m_pend || loc)) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
        spi_win = m_pend;
`else
        spi_win = m_pend && (!loc || m_last_local);
`endif
        e_en[cyc+1]   = 1;
        e_busy[cyc+1] = 1;
        e_busy[cyc+2] = 1;
        if (spi_win) begin
          e_we[cyc+1]   = m_pwe;
          e_addr[cyc+1] = m_paddr;
          e_wd[cyc+1]   = m_pdata;
          e_txv[cyc+3]  = !m_pwe;
          m_pend        = 0;
        end else begin
          e_we[cyc+1]   = b_we;
          e_addr[cyc+1] = b_addr;
          e_wd[cyc+1]   = b_wdata;
          e_back[cyc+3] = 1;
        end
        m_last_local = !spi_win;
        m_free       = cyc + 3;
      end
      if (rx_valid) begin
        op = rx_data[W+1:W];
        pl = rx_data[W-1:0];
        if (op == 2'b00)      m_wr = pl;
        else if (op == 2'b10) m_rd = pl;
        else if (pend0)       m_ovf = 1;
        else begin
          m_pend  = 1;
          m_pwe   = (op == 2'b01);
          m_paddr = (op == 2'b01) ? m_wr : m_rd;
          m_pdata = pl;
        end
      end
    end
    cyc++;
    if (e_txv[cyc]) m_tx_data = e_rd[cyc];
    if (e_back[cyc] && !e_we[cyc-2]) m_b_rdata = e_rd[cyc];
  end

  always @(negedge clk) begin : compare
    if (rst) begin
      check("reset_outputs_zero",
            |{ram_en, ram_we, tx_valid, b_ack, a_ovf, busy, tx_data, b_rdata, ram_addr, ram_wdata},
            1'b0);
    end else begin
      check("ram_en", ram_en, e_en[cyc]);
      check("ram_we", ram_we, e_en[cyc] && e_we[cyc]);
      if (e_en[cyc]) begin
        check("ram_addr", ram_addr, e_addr[cyc]);
        if (e_we[cyc]) check("ram_wdata", ram_wdata, e_wd[cyc]);
      end
      check("tx_valid", tx_valid, e_txv[cyc]);
      check("tx_data", tx_data, m_tx_data);
      check("b_ack", b_ack, e_back[cyc]);
      check("b_rdata", b_rdata, m_b_rdata);
      check("a_ovf", a_ovf, m_ovf);
      check("busy", busy, e_busy[cyc]);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi(input logic [1:0] op, input logic [W-1:0] pl);
    rx_data  = {op, pl};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    b_req    = 1'b0;
    rx_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic new_req();
    b_req   = 1'b1;
    b_we    = 1'($urandom_range(0, 1));
    b_addr  = 8'($urandom_range(0, 15));
    b_wdata = 8'($urandom);
  endtask

  initial begin : driver
    int w40_start;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'(i) ^ 8'h5A;
      mmem[i]    = 8'(i) ^ 8'h5A;
    end
    rst = 1'b1;
    #1;
    tick();
    check("reset_busy", busy, 1'b0);
    check("reset_ram_en", ram_en, 1'b0);
    tick();
    rst = 1'b0;

    // SPI write then read of address 0x05
    spi(2'b00, 8'h05);
    spi(2'b01, 8'hA5);
    spi(2'b10, 8'h05);
    check("spi_wr_en", ram_en, 1'b1);
    check("spi_wr_we", ram_we, 1'b1);
    check("spi_wr_addr", ram_addr, 8'h05);
    check("spi_wr_data", ram_wdata, 8'hA5);
    repeat (3) tick();
    spi(2'b11, 8'h00);
    tick();
    check("spi_rd_en", ram_en, 1'b1);
    check("spi_rd_we", ram_we, 1'b0);
    check("spi_rd_addr", ram_addr, 8'h05);
    tick();
    tick();
    check("spi_rd_txv", tx_valid, 1'b1);
    check("spi_rd_txd", tx_data, 8'hA5);

    // Local write 0x3C to 0x10, then local read (request changed in ack cycle)
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h10; b_wdata = 8'h3C;
    tick();
    check("loc_wr_en", ram_en, 1'b1);
    check("loc_wr_addr", ram_addr, 8'h10);
    check("loc_wr_data", ram_wdata, 8'h3C);
    tick();
    tick();
    check("loc_wr_ack", b_ack, 1'b1);
    b_we = 1'b0;
    tick();
    check("loc_req_ignored_in_ack", ram_en, 1'b0);
    tick();
    check("loc_rd_en", ram_en, 1'b1);
    check("loc_rd_we", ram_we, 1'b0);
    tick();
    tick();
    check("loc_rd_ack", b_ack, 1'b1);
    check("loc_rd_data", b_rdata, 8'h3C);
    b_req = 1'b0;

    // Tie after reset: SPI first, local three cycles later
    do_reset();
    spi(2'b10, 8'h20);
    spi(2'b11, 8'h00);
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
    tick();
    check("tie_first_en", ram_en, 1'b1);
    check("tie_first_addr", ram_addr, 8'h20);
    tick();
    tick();
    check("tie_spi_txv", tx_valid, 1'b1);
    check("tie_spi_no_back", b_ack, 1'b0);
    check("tie_spi_txd", tx_data, 8'h7A);
    repeat (3) tick();
    check("tie_loc_ack", b_ack, 1'b1);
    check("tie_loc_no_txv", tx_valid, 1'b0);
    check("tie_loc_rdata", b_rdata, 8'h7A);
    b_req = 1'b0;

    // Overflow: second write while the first is still pending is dropped
    w40_start = wr40_cnt;
    spi(2'b00, 8'h40);
    spi(2'b01, 8'h11);
    spi(2'b01, 8'h22);
    repeat (4) tick();
    check("ovf_flag", a_ovf, 1'b1);
    check("ovf_one_write", wr40_cnt - w40_start, 1);
    check("ovf_ram_value", ram_mem[8'h40], 8'h11);

    // Reset during ACCESS aborts the write with no strobe
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h40; b_wdata = 8'h99;
    tick();
    check("abort_pre_en", ram_en, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_en_now", ram_en, 1'b0);
    check("abort_ovf_clr", a_ovf, 1'b0);
    b_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_strobe", tx_valid | b_ack, 1'b0);
    end
    spi(2'b10, 8'h40);
    spi(2'b11, 8'h00);
    repeat (3) tick();
    check("after_abort_txv", tx_valid, 1'b1);
    check("after_abort_txd", tx_data, 8'h11);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (b_req && b_ack) begin
        if ($urandom_range(0, 1) == 0) b_req = 1'b0;
        else new_req();
      end else if (!b_req && $urandom_range(0, 2) == 0) begin
        new_req();
      end
      rx_valid = ($urandom_range(0, 9) < 3);
      rx_data[W+1:W] = 2'($urandom_range(0, 3));
      rx_data[W-1:0] = rx_data[W] ? 8'($urandom) : 8'($urandom_range(0, 15));
      tick();
    end
    rst      = 1'b0;
    rx_valid = 1'b0;
    b_req    = 1'b0;
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving both the RAM address width and the RAM data width.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  WIDTH+2  SPI command word: [WIDTH+1:WIDTH] opcode, [WIDTH-1:0] payload.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- tx_data  out  WIDTH  SPI read-return data.
- tx_valid  out  1  one-cycle strobe qualifying tx_data.
- b_req  in  1  local requester level request; held until b_ack.
- b_we  in  1  local write (1) or read (0); stable while b_req is high.
- b_addr  in  WIDTH  local address; stable while b_req is high.
- b_wdata  in  WIDTH  local write data; stable while b_req is high.
- b_ack  out  1  one-cycle completion strobe to the local requester.
- b_rdata  out  WIDTH  local read data, valid with b_ack.
- ram_en  out  1  single-port RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  WIDTH  RAM address.
- ram_wdata  out  WIDTH  RAM write data.
- ram_rdata  in  WIDTH  RAM read data, valid one cycle after ram_en=1 with ram_we=0.
- a_ovf  out  1  sticky flag: SPI RAM command dropped.
- busy  out  1  high when the FSM is not in IDLE.

Function
REQ-003 Opcode 00 SHALL load the SPI write-address register from the payload; opcode 10 SHALL load the SPI read-address register; neither SHALL access RAM.
REQ-004 Opcode 01 (write payload at the write address) and opcode 11 (read at the read address) SHALL set a one-deep SPI pending request.
REQ-005 An opcode 01/11 strobe arriving while the SPI request is already pending SHALL be dropped and SHALL set a_ovf.
REQ-006 The FSM SHALL have three states, IDLE, ACCESS and WAIT; busy SHALL be high in ACCESS and WAIT.
REQ-007 In IDLE, when at least one request is pending, the FSM SHALL latch the winner's command and move to ACCESS.
REQ-008 In ACCESS, ram_en SHALL be 1 for exactly one cycle, with ram_we, ram_addr and ram_wdata taken from the latched command; the FSM then SHALL move to WAIT.
REQ-009 In WAIT, the FSM SHALL capture ram_rdata on read commands and return to IDLE.
REQ-010 On the edge from WAIT to IDLE, the completion strobe SHALL be registered:
- SPI read: tx_valid=1 with tx_data set to the captured data.
- SPI write: no strobe.
- Local read or write: b_ack=1; b_rdata is updated on reads only.
REQ-011 Latency SHALL be fixed: request seen in IDLE at cycle N -> ram_en at N+1 -> strobe at N+3; back-to-back accesses every 3 cycles.
REQ-012 b_req SHALL be ignored in the cycle in which b_ack=1.
REQ-013 With both requests pending in IDLE, the grant SHALL go to the requester not granted last (round-robin); last-grant resets to local, so SPI wins the first tie.
REQ-014 An SPI strobe arriving while the FSM is busy SHALL be captured into pending without disturbing the access in flight.
REQ-015 ram_en, ram_we, tx_valid and b_ack SHALL be 0 whenever not asserted by REQ-008 or REQ-010.
REQ-016 Address registers SHALL use the payload as-is, with no increment and no wrap logic.

Reset
REQ-017 rst SHALL immediately force:
- FSM to IDLE.
- All outputs to 0.
- Both address registers, pending request, captured data and a_ovf to 0.
- Last-grant to local.
REQ-018 Reset asserted mid-access SHALL abort the access with no strobe; a_ovf SHALL be cleared only by rst.

Configuration
REQ-019 With macro SPI_ARB_FIXED_PRIO_EN defined, SPI SHALL always win a tie and the last-grant register SHALL be omitted; without it, REQ-013 round-robin applies.

Verification
REQ-020 SPI 0x005, then 0x1A5, then 0x205, then 0x305 -> ram write addr 0x05 data 0xA5; three cycles after the read strobe, tx_valid=1 with tx_data=0xA5.
REQ-021 b_req=1, b_we=1, b_addr=0x10, b_wdata=0x3C, then a local read of 0x10 -> b_ack pulses at N+3 for each; b_rdata=0x3C.
REQ-022 SPI read and local read of 0x20 pending in the same IDLE cycle after reset -> SPI granted first, local granted next; strobes 3 cycles apart (with macro: SPI first always).
REQ-023 Two SPI opcode-01 strobes while the first is still pending -> second is dropped, a_ovf=1, and exactly one RAM write occurs.
REQ-024 rst pulsed during ACCESS -> ram_en=0 immediately, no tx_valid/b_ack, a_ovf=0; a subsequent command completes normally.
